// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-phase select type and default address map.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DSEL_NONE    = 2'd0,
        DSEL_SLAVE   = 2'd1,
        DSEL_DEFAULT = 2'd2
    } dsel_t;

    localparam int DEF_NUM_SLAVES = 3;

    localparam logic [2:0][31:0] DEF_SLAVE_BASE = {
        32'h8001_0000, 32'h8000_0000, 32'h0000_0000
    };
    localparam logic [2:0][31:0] DEF_SLAVE_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000
    };

    function automatic logic is_active(input logic [1:0] t);
        return !((t == HTRANS_IDLE) || (t == HTRANS_BUSY));
    endfunction

endpackage

// File: rtl/ahb_slave_decode_mux_if.sv
// Master-side request/response and per-slave fan-out signals of the decoder.
interface ahb_slave_decode_mux_if #(
    parameter int NUM_SLAVES = 3
);

    logic [1:0]  m_HTRANS;
    logic        m_HWRITE;
    logic [31:0] m_HADDR;
    logic [31:0] m_HWDATA;
    logic [2:0]  m_HSIZE;
    logic [2:0]  m_HBURST;
    logic [3:0]  m_HPROT;
    logic        m_HMASTLOCK;
    logic        m_HREADY;
    logic [1:0]  m_HRESP;
    logic [31:0] m_HRDATA;

    logic [1:0]            s_HTRANS    [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] s_HWRITE;
    logic [31:0]           s_HADDR     [NUM_SLAVES];
    logic [31:0]           s_HWDATA    [NUM_SLAVES];
    logic [2:0]            s_HSIZE     [NUM_SLAVES];
    logic [2:0]            s_HBURST    [NUM_SLAVES];
    logic [3:0]            s_HPROT     [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] s_HMASTLOCK;
    logic [NUM_SLAVES-1:0] s_HSEL;
    logic [NUM_SLAVES-1:0] s_HREADY;
    logic [NUM_SLAVES-1:0] s_HREADYOUT;
    logic [1:0]            s_HRESP     [NUM_SLAVES];
    logic [31:0]           s_HRDATA    [NUM_SLAVES];

    modport slave (
        input  m_HTRANS, m_HWRITE, m_HADDR, m_HWDATA,
        input  m_HSIZE, m_HBURST, m_HPROT, m_HMASTLOCK,
        output m_HREADY, m_HRESP, m_HRDATA,
        output s_HTRANS, s_HWRITE, s_HADDR, s_HWDATA,
        output s_HSIZE, s_HBURST, s_HPROT, s_HMASTLOCK,
        output s_HSEL, s_HREADY,
        input  s_HREADYOUT, s_HRESP, s_HRDATA
    );

    modport master (
        output m_HTRANS, m_HWRITE, m_HADDR, m_HWDATA,
        output m_HSIZE, m_HBURST, m_HPROT, m_HMASTLOCK,
        input  m_HREADY, m_HRESP, m_HRDATA,
        input  s_HTRANS, s_HWRITE, s_HADDR, s_HWDATA,
        input  s_HSIZE, s_HBURST, s_HPROT, s_HMASTLOCK,
        input  s_HSEL, s_HREADY,
        output s_HREADYOUT, s_HRESP, s_HRDATA
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       i_capture,
    input  logic       i_unmapped_active,
    output logic       o_hreadyout,
    output logic [1:0] o_hresp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_start;

    assign w_start = i_capture && i_unmapped_active;

    always_comb begin
        w_next = r_state;
        unique case (1'b1)
            (r_state == ST_IDLE): if (w_start) w_next = ST_ERR1;
            (r_state == ST_ERR1): w_next = ST_ERR2;
            (r_state == ST_ERR2): begin
                if (i_capture) w_next = w_start ? ST_ERR1 : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    assign o_hreadyout = (r_state != ST_ERR1);
    assign o_hresp     = (r_state == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_slave_decode_mux.sv
// AHB-Lite address decoder and data-phase response multiplexer for one master.
module ahb_slave_decode_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_slave_decode_mux_if.slave bus
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic          w_hit;
    logic [IW-1:0] w_idx;
    logic          w_cap;
    logic          w_ua;
    logic          w_dflt_rdy;
    logic [1:0]    w_dflt_resp;
    logic          w_rdy;
    logic [1:0]    w_resp;
    logic [31:0]   w_rdata;

    dsel_t         r_dsel;
    logic [IW-1:0] r_idx;
    logic          r_dactive;

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_fan
        assign bus.s_HTRANS[g]    = bus.m_HTRANS;
        assign bus.s_HWRITE[g]    = bus.m_HWRITE;
        assign bus.s_HADDR[g]     = bus.m_HADDR;
        assign bus.s_HWDATA[g]    = bus.m_HWDATA;
        assign bus.s_HSIZE[g]     = bus.m_HSIZE;
        assign bus.s_HBURST[g]    = bus.m_HBURST;
        assign bus.s_HPROT[g]     = bus.m_HPROT;
        assign bus.s_HMASTLOCK[g] = bus.m_HMASTLOCK;
        assign bus.s_HSEL[g]      = w_hit && (w_idx == IW'(g));
        assign bus.s_HREADY[g]    = w_rdy;
    end

    assign w_cap = w_rdy;
    assign w_ua  = !w_hit && is_active(bus.m_HTRANS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel    <= DSEL_NONE;
            r_idx     <= '0;
            r_dactive <= 1'b0;
        end else if (w_cap) begin
            r_dsel    <= w_hit ? DSEL_SLAVE : DSEL_DEFAULT;
            r_idx     <= w_idx;
            r_dactive <= is_active(bus.m_HTRANS);
        end
    end

    ahb_default_slave u_dflt (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .i_capture         (w_cap),
        .i_unmapped_active (w_ua),
        .o_hreadyout       (w_dflt_rdy),
        .o_hresp           (w_dflt_resp)
    );

    // The mux follows the data-phase owner, never the live HSEL.
    always_comb begin
        w_rdy   = 1'b1;
        w_resp  = HRESP_OKAY;
        w_rdata = '0;
        unique case (1'b1)
            (r_dsel == DSEL_SLAVE): begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_idx == IW'(i)) begin
                        w_rdy   = bus.s_HREADYOUT[i];
                        w_resp  = bus.s_HRESP[i];
                        w_rdata = bus.s_HRDATA[i];
                    end
                end
            end
            (r_dsel == DSEL_DEFAULT && r_dactive): begin
                w_rdy  = w_dflt_rdy;
                w_resp = w_dflt_resp;
            end
            default: ;
        endcase
    end

    assign bus.m_HREADY = w_rdy;
    assign bus.m_HRESP  = w_resp;
    assign bus.m_HRDATA = w_rdata;

endmodule

// File: tb/tb_ahb_slave_decode_mux.sv
// Directed bench for ahb_slave_decode_mux with a per-cycle reference model.
module tb_ahb_slave_decode_mux;

    localparam int N = 3;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_slave_decode_mux_if #(.NUM_SLAVES(N)) bus ();

    ahb_slave_decode_mux #(.NUM_SLAVES(N)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] rbase [N] = '{32'h0000_0000, 32'h8000_0000, 32'h8001_0000};
    logic [31:0] rmask [N] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    // Model: who owns the data phase (-1 none, -2 default slave, else index),
    // whether it is an active transfer and how many cycles it has lasted.
    int mo_owner  = -1;
    bit mo_active = 1'b0;
    int mo_age    = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int owner_of(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & rmask[i]) == rbase[i]) return i;
        return -2;
    endfunction

    function automatic logic exp_ready();
        if (mo_owner >= 0) return bus.s_HREADYOUT[mo_owner];
        if (mo_owner == -2 && mo_active) return (mo_age != 0);
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_resp();
        if (mo_owner >= 0) return bus.s_HRESP[mo_owner];
        if (mo_owner == -2 && mo_active) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (mo_owner >= 0) return bus.s_HRDATA[mo_owner];
        return 32'h0;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mo_owner  <= -1;
            mo_active <= 1'b0;
            mo_age    <= 0;
        end else if (exp_ready()) begin
            mo_owner  <= owner_of(bus.m_HADDR);
            mo_active <= (bus.m_HTRANS >= 2'b10);
            mo_age    <= 0;
        end else begin
            mo_age    <= mo_age + 1;
        end
    end

    always @(negedge HCLK) begin
        logic [N-1:0] hs;
        for (int i = 0; i < N; i++) hs[i] = (owner_of(bus.m_HADDR) == i);
        chk("m_HREADY", bus.m_HREADY, exp_ready());
        chk("m_HRESP", bus.m_HRESP, exp_resp());
        chk("m_HRDATA", bus.m_HRDATA, exp_rdata());
        chk("s_HSEL", bus.s_HSEL, hs);
        chk("s_HREADY", bus.s_HREADY, {N{exp_ready()}});
        for (int i = 0; i < N; i++) begin
            chk("bcast_ctl",
                {bus.s_HTRANS[i], bus.s_HWRITE[i], bus.s_HSIZE[i],
                 bus.s_HBURST[i], bus.s_HPROT[i], bus.s_HMASTLOCK[i]},
                {bus.m_HTRANS, bus.m_HWRITE, bus.m_HSIZE,
                 bus.m_HBURST, bus.m_HPROT, bus.m_HMASTLOCK});
            chk("bcast_addr", bus.s_HADDR[i], bus.m_HADDR);
            chk("bcast_wdata", bus.s_HWDATA[i], bus.m_HWDATA);
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic [1:0] t, input logic w,
                       input logic [31:0] a);
        bus.m_HTRANS = t;
        bus.m_HWRITE = w;
        bus.m_HADDR  = a;
    endtask

    task automatic resp_chk(input string n, input logic rdy,
                            input logic [1:0] rsp);
        chk({n, "_rdy"}, bus.m_HREADY, rdy);
        chk({n, "_resp"}, bus.m_HRESP, rsp);
    endtask

    initial begin
        bus.m_HTRANS    = 2'b00;
        bus.m_HWRITE    = 1'b0;
        bus.m_HADDR     = 32'h0;
        bus.m_HWDATA    = 32'h0;
        bus.m_HSIZE     = 3'b010;
        bus.m_HBURST    = 3'b000;
        bus.m_HPROT     = 4'b0011;
        bus.m_HMASTLOCK = 1'b0;
        bus.s_HREADYOUT = '1;
        for (int i = 0; i < N; i++) begin
            bus.s_HRESP[i]  = 2'b00;
            bus.s_HRDATA[i] = 32'h0;
        end
        bus.s_HRDATA[0] = 32'h0000_1234;

        // Reset values
        tick();
        tick();
        settle();
        resp_chk("rst", 1'b1, 2'b00);
        chk("rst_rdata", bus.m_HRDATA, 32'h0);
        chk("rst_s_hready", bus.s_HREADY, 3'b111);
        bus.s_HRDATA[0] = 32'h0;
        HRESETn = 1'b1;

        // Waited read from slave 1
        tick();
        req(2'b10, 1'b0, 32'h8000_0010);
        settle();
        chk("rd_hsel", bus.s_HSEL, 3'b010);
        tick();
        req(2'b00, 1'b0, 32'h0);
        bus.s_HREADYOUT[1] = 1'b0;
        settle();
        chk("rd_wait1", bus.m_HREADY, 1'b0);
        tick();
        settle();
        chk("rd_wait2", bus.m_HREADY, 1'b0);
        tick();
        bus.s_HREADYOUT[1] = 1'b1;
        bus.s_HRDATA[1]    = 32'hDEAD_BEEF;
        settle();
        resp_chk("rd_done", 1'b1, 2'b00);
        chk("rd_data", bus.m_HRDATA, 32'hDEAD_BEEF);
        tick();
        bus.s_HRDATA[1] = 32'h0;

        // Back-to-back writes: slave 0 then slave 2
        req(2'b10, 1'b1, 32'h0000_0004);
        settle();
        chk("wr0_hsel", bus.s_HSEL, 3'b001);
        tick();
        req(2'b10, 1'b1, 32'h8001_0008);
        bus.m_HWDATA       = 32'h1111_1111;
        bus.s_HREADYOUT[2] = 1'b0;
        settle();
        chk("wr2_hsel", bus.s_HSEL, 3'b100);
        chk("wr0_track", bus.m_HREADY, 1'b1);
        chk("wr0_wdata", bus.s_HWDATA[2], 32'h1111_1111);
        tick();
        req(2'b00, 1'b0, 32'h0);
        bus.m_HWDATA   = 32'h2222_2222;
        bus.s_HRESP[0] = 2'b01;
        settle();
        resp_chk("wr2_track", 1'b0, 2'b00);
        tick();
        bus.s_HREADYOUT[2] = 1'b1;
        bus.s_HRESP[0]     = 2'b00;
        settle();
        chk("wr2_done", bus.m_HREADY, 1'b1);
        chk("wr2_wdata", bus.s_HWDATA[0], 32'h2222_2222);
        tick();
        bus.m_HWDATA = 32'h0;

        // Unmapped NONSEQ then unmapped IDLE
        req(2'b10, 1'b0, 32'hC000_0000);
        settle();
        chk("um_hsel", bus.s_HSEL, 3'b000);
        tick();
        req(2'b00, 1'b0, 32'hC000_0000);
        settle();
        resp_chk("um_c1", 1'b0, 2'b01);
        tick();
        settle();
        resp_chk("um_c2", 1'b1, 2'b01);
        tick();
        settle();
        resp_chk("um_idle", 1'b1, 2'b00);

        // Two consecutive unmapped NONSEQs
        req(2'b10, 1'b0, 32'hC000_0000);
        tick();
        req(2'b10, 1'b0, 32'hD000_0000);
        settle();
        resp_chk("b2b_e1a", 1'b0, 2'b01);
        tick();
        settle();
        resp_chk("b2b_e2a", 1'b1, 2'b01);
        tick();
        req(2'b00, 1'b0, 32'h0);
        settle();
        resp_chk("b2b_e1b", 1'b0, 2'b01);
        tick();
        settle();
        resp_chk("b2b_e2b", 1'b1, 2'b01);
        tick();
        settle();
        resp_chk("b2b_idle", 1'b1, 2'b00);

        // Reset while in ERR1, then a mapped read
        req(2'b10, 1'b0, 32'hC000_0000);
        tick();
        req(2'b00, 1'b0, 32'h0);
        settle();
        resp_chk("pre_rst", 1'b0, 2'b01);
        HRESETn = 1'b0;
        settle();
        resp_chk("mid_rst", 1'b1, 2'b00);
        chk("mid_rst_rdata", bus.m_HRDATA, 32'h0);
        chk("mid_rst_s_hready", bus.s_HREADY, 3'b111);
        tick();
        HRESETn = 1'b1;
        settle();
        resp_chk("post_rst", 1'b1, 2'b00);
        req(2'b10, 1'b0, 32'h8001_0020);
        settle();
        chk("rd2_hsel", bus.s_HSEL, 3'b100);
        tick();
        req(2'b00, 1'b0, 32'h0);
        bus.s_HRDATA[2] = 32'hCAFE_F00D;
        settle();
        resp_chk("rd2_done", 1'b1, 2'b00);
        chk("rd2_data", bus.m_HRDATA, 32'hCAFE_F00D);
        tick();
        bus.s_HRDATA[2] = 32'h0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
